muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_datapath.sv | 68 ++++++
 rtl/muldiv_sequencer.sv | 150 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// Used by muldiv_if, muldiv_datapath and muldiv_sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Encodings match the M-extension func3 field.
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between decode/execute and the mul/div sequencer.
// Signal suffixes are written from the sequencer's point of view.
interface muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs1_i;
  logic [WIDTH-1:0] rs2_i;
  logic             flush_i;
  logic             busy_o;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  busy_o, stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output busy_o, stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Shared shift-add multiplier / restoring divider working on operand magnitudes.
// The divider step is compiled only when MULDIV_DIV_EN is defined.
module muldiv_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_nxt_o,
  output logic [WIDTH-1:0] lo_nxt_o
);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH:0]   add_sum;

  // hi holds the partial product (or remainder), lo the multiplier (or quotient).
  assign add_sum = {1'b0, hi_q} + ({1'b0, b_q} & {(WIDTH+1){lo_q[0]}});

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic             unused_diff;

  assign shifted     = {hi_q, lo_q[WIDTH-1]};
  assign diff        = {1'b0, shifted} - {2'b00, b_q};
  assign ge          = ~diff[WIDTH+1];
  assign unused_diff = diff[WIDTH];
`else
  logic unused_div;
  assign unused_div = div_i;
`endif

  always_comb begin
    hi_d = add_sum[WIDTH:1];
    lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (div_i) begin
      hi_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ge};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= a_i;
      b_q  <= b_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_nxt_o = hi_d;
  assign lo_nxt_o = lo_d;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative mul/div controller: FSM, counter, stall and sign handling.
// Divide ops are fully supported only with MULDIV_DIV_EN defined; otherwise they return 0 fast.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int unsigned   CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  op_e              op_q;
  logic             neg_q;
  logic [WIDTH-1:0] result_q;

  op_e              op_in;
  logic             accept;
  logic             sign_a, sign_b, neg_a, neg_b, neg_res;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             fast;
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] calc_res;

  assign op_in  = op_e'(bus.op_i);
  assign accept = (state_q == StIdle) & bus.start_i & ~bus.flush_i;

  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    unique case (op_in)
      OpMulh, OpDiv, OpRem: begin
        sign_a = 1'b1;
        sign_b = 1'b1;
      end
      OpMulhsu: sign_a = 1'b1;
      default: ;
    endcase
  end

  assign neg_a   = sign_a & bus.rs1_i[WIDTH-1];
  assign neg_b   = sign_b & bus.rs2_i[WIDTH-1];
  assign a_mag   = neg_a ? -bus.rs1_i : bus.rs1_i;
  assign b_mag   = neg_b ? -bus.rs2_i : bus.rs2_i;
  // Remainder follows the dividend; everything else follows the operand sign product.
  assign neg_res = (op_in == OpRem) ? neg_a : (neg_a ^ neg_b);

`ifdef MULDIV_DIV_EN
  logic div_zero, div_ovf;

  assign div_zero = bus.op_i[2] & (bus.rs2_i == '0);
  assign div_ovf  = ((op_in == OpDiv) | (op_in == OpRem)) &
                    (bus.rs1_i == WIDTH'(SIGNED_MIN)) & (bus.rs2_i == '1);
  assign fast     = div_zero | div_ovf;

  always_comb begin
    if (div_zero) begin
      fast_res = bus.op_i[1] ? bus.rs1_i : WIDTH'(DIV_ZERO_Q);
    end else begin
      fast_res = bus.op_i[1] ? '0 : WIDTH'(SIGNED_MIN);
    end
  end
`else
  assign fast     = bus.op_i[2];
  assign fast_res = '0;
`endif

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .step_i  ((state_q == StCalc) & ~bus.flush_i),
    .div_i   (op_q[2]),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .hi_nxt_o(hi_nxt),
    .lo_nxt_o(lo_nxt)
  );

  // Result is formed from the final step's next values so it can be registered into DONE.
  assign prod   = {hi_nxt, lo_nxt};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    calc_res = '0;
    unique case (op_q)
      OpMul:                     calc_res = prod_s[WIDTH-1:0];
      OpMulh, OpMulhsu, OpMulhu: calc_res = prod_s[2*WIDTH-1:WIDTH];
`ifdef MULDIV_DIV_EN
      OpDiv, OpDivu:             calc_res = neg_q ? -lo_nxt : lo_nxt;
      OpRem, OpRemu:             calc_res = neg_q ? -hi_nxt : hi_nxt;
`endif
      default:                   calc_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q  <= op_in;
            neg_q <= neg_res;
            cnt_q <= '0;
            if (fast) begin
              result_q <= fast_res;
              state_q  <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (bus.flush_i) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              result_q <= calc_res;
              state_q  <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy_o   = (state_q != StIdle);
  assign bus.stall_o  = accept | (state_q == StCalc);
  assign bus.done_o   = (state_q == StDone) & ~bus.flush_i;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results queued at issue, checked on done_o.
// Divide expectations follow MULDIV_DIV_EN exactly as the RTL build does.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int          sa, sbv;
    longint      p;
    logic [63:0] pu;
    sa  = a;
    sbv = b;
    case (op)
      3'b000: return a * b;
      3'b001: begin
        p = longint'(sa) * longint'(sbv);
        return p[63:32];
      end
      3'b010: begin
        p = longint'(sa) * longint'({32'b0, b});
        return p[63:32];
      end
      3'b011: begin
        pu = {32'b0, a} * {32'b0, b};
        return pu[63:32];
      end
`ifdef MULDIV_DIV_EN
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sbv;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sbv;
      end
      3'b111: return (b == 0) ? a : a % b;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (!op[2]) return 1'b0;
`ifdef MULDIV_DIV_EN
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
    return 1'b1;
`endif
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done_o) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'b0, bus.done_o}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        last_res = mon_e.res;
        check(mon_e.tag, {32'b0, bus.result_o}, {32'b0, mon_e.res});
        check({mon_e.tag, "_cycle"}, {32'b0, cyc}, {32'b0, mon_e.cyc});
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy_o; i++) begin
      @(posedge clk);
      #1;
    end
    if (bus.busy_o) check("idle_timeout", {63'b0, bus.busy_o}, 64'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && (sb.size() != 0 || bus.busy_o); i++) begin
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0) check("done_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Returns one time unit after the accepting edge, i.e. in cycle N+1.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit track);
    wait_idle();
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.start_i = 1'b1;
    #1;
    check({tag, "_stall_req"}, {63'b0, bus.stall_o}, 64'd1);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    if (track) sb.push_back('{model(op, a, b), is_fast(op, a, b) ? cyc : cyc + W, tag});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = 3'b000;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, bus.busy_o}, 64'd0);
    check("rst_stall", {63'b0, bus.stall_o}, 64'd0);
    check("rst_done", {63'b0, bus.done_o}, 64'd0);
    check("rst_result", {32'b0, bus.result_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // MUL 7 x -3 with stall profile: N checked in issue, N+1..N+32 counted here.
    issue("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1);
    sc = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.stall_o) sc++;
      @(posedge clk);
      #1;
    end
    check("mul_stall_cycles", 64'(sc), 64'd32);

    issue("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue("mulh_ff", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue("mulhsu", 3'b010, 32'hFFFF_FFF0, 32'h8000_0001, 1'b1);
    issue("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue("divu_100_7", 3'b101, 32'd100, 32'd7, 1'b1);
    issue("remu_100_7", 3'b111, 32'd100, 32'd7, 1'b1);
    issue("div_5_0", 3'b100, 32'd5, 32'd0, 1'b1);
    issue("rem_5_0", 3'b110, 32'd5, 32'd0, 1'b1);
    issue("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();

    // Flush in CALC cycle 10; a stray start mid-CALC must be ignored.
    issue("flushed", 3'b000, 32'd5, 32'd6, 1'b0);
    for (int i = 1; i < 10; i++) begin
      bus.start_i = (i == 5);
      bus.op_i    = 3'b101;
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b0;
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    check("flush_busy", {63'b0, bus.busy_o}, 64'd0);
    check("flush_stall", {63'b0, bus.stall_o}, 64'd0);
    check("flush_result_hold", {32'b0, bus.result_o}, {32'b0, last_res});
    repeat (3) @(posedge clk);
    #1;
    issue("mul_3_4", 3'b000, 32'd3, 32'd4, 1'b1);
    wait_done();

    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      issue($sformatf("rand%0d_op%0d", i, op), op, a, b, 1'b1);
    end
    wait_done();

    // Reset in the middle of CALC discards the operation and zeroes outputs.
    issue("rst_victim", 3'b000, 32'd9, 32'd9, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", {63'b0, bus.busy_o}, 64'd0);
    check("midrst_stall", {63'b0, bus.stall_o}, 64'd0);
    check("midrst_done", {63'b0, bus.done_o}, 64'd0);
    check("midrst_result", {32'b0, bus.result_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue("divu_9_3", 3'b101, 32'd9, 32'd3, 1'b1);
    wait_done();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
